imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_byte.sv | 45 ++++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader slice.
//   BYTES_PER_WORD : bytes assembled into one 32-bit instruction word
//   BYTE_CNT_W     : width of the byte counter inside byte_assembler
//   load_state_t   : loader FSM states
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CSUM state.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // Encodings are fixed so CSUM can be removed without renumbering the rest.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } load_state_t;

endpackage

// File: rtl/imem_loader_byte.sv
// byte_assembler
// Packs a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst    : clock and synchronous active-low reset
//   clear       : drops any partially assembled word
//   byte_en     : a byte is transferred this cycle
//   byte_data   : the transferred byte
//   word_valid  : high for the single cycle in which the 4th byte transfers
//   word        : the completed word, valid while word_valid is high
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [31:0]           shift_reg;

  // Bytes enter at the top and move down, so after four bytes the first one
  // sits in [7:0]. The counter wraps naturally after the 4th byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (clear) begin
      byte_cnt  <= '0;
    end else if (byte_en) begin
      byte_cnt  <= byte_cnt + BYTE_CNT_W'(1);
      shift_reg <= {byte_data, shift_reg[31:8]};
    end
  end

  // The completed word is presented in the same cycle as its 4th byte so the
  // loader can register it at that edge; this keeps the write one cycle
  // after the last byte.
  assign word_valid = byte_en && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, shift_reg[31:8]};

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Receives a byte stream of the form [N][word 0]..[word N-1] (and, when
// IMEM_LOADER_CHECKSUM_EN is defined, a trailing sum-of-words checksum),
// writes the words to instruction memory at byte addresses 0,4,8,... and
// then releases the core from reset.
// Ports:
//   clk, rst              : clock and synchronous active-low reset
//   start                 : one-cycle pulse that begins a load
//   byte_valid/byte_data  : offered stream byte
//   byte_ready            : loader accepts a byte (HDR, DATA, CSUM)
//   mem_we/mem_addr/mem_wd: instruction-memory write port
//   core_rst_n            : 0 holds the core in reset; 1 only once loaded
//   done / error          : load completed / load aborted
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam load_state_t AFTER_DATA = CSUM;
`else
  localparam load_state_t AFTER_DATA = DONE;
`endif

  load_state_t state;
  load_state_t state_next;

  logic        xfer;
  logic        asm_clear;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic [31:0] word_count;
  logic [31:0] word_idx;
  logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  assign xfer      = byte_valid && byte_ready;
  // A new load can only begin from a state where no bytes are accepted, so
  // clearing the assembler here never collides with a transfer.
  assign asm_clear = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign last_word = (word_idx == (word_count - 32'd1));

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_en    (xfer),
    .byte_data  (byte_data),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs. Start is only honoured from the
  // resting states; during a load it has no effect.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = HDR;
      end
      HDR: begin
        byte_ready = 1'b1;
        if (asm_valid) begin
          if (asm_word > MAX_WORDS) begin
            state_next = ERR;
          end else if (asm_word != 32'd0) begin
            state_next = DATA;
          end else begin
            state_next = AFTER_DATA;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (asm_valid && last_word) state_next = AFTER_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        byte_ready = 1'b1;
        if (asm_valid) begin
          if (asm_word == csum) begin
            state_next = DONE;
          end else begin
            state_next = ERR;
          end
        end
      end
`endif
      DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
        if (start) state_next = HDR;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_next = HDR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: header capture, write strobe, address/data registers (which
  // simply keep their value between writes) and the running checksum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      word_count <= '0;
      word_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (asm_clear) begin
        word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if ((state == HDR) && asm_valid) begin
        word_count <= asm_word;
      end
      if ((state == DATA) && asm_valid) begin
        mem_we   <= 1'b1;
        mem_addr <= {word_idx[29:0], 2'b00};
        mem_wd   <= asm_word;
        word_idx <= word_idx + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= csum + asm_word;
`endif
      end
    end
  end

endmodule
